cascade_sequencer: RTL and testbench
====================================

# cascade_sequencer

Parametrised, clocked successor to the PIC cascade controller. It runs the full INTA acknowledge sequence for a master or slave 8259A-style controller in 8086 (two-pulse) or 8080 (three-pulse) mode. The block owns the CAS bus drive and enables, selects which device places vector bytes on the data bus, and recovers from aborted sequences via EOI or a timeout. It sits between the control logic, the priority resolver and the CAS pins.

## Interface
- CAS_W, 3: cascade line width; the block supports up to 2**CAS_W slaves.
- TIMEOUT, 255: cycles without a strobe before an active sequence aborts; must be ≥1.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- sp  in  1  1 = master, 0 = slave; sampled at strobe #1.
- mode_8080  in  1  1 = three INTA pulses, 0 = two; sampled at strobe #1.
- icw3  in  2**CAS_W  master: bit i set means IR i has a slave; slave: bits [CAS_W-1:0] are the own ID.
- grant_valid  in  1  priority resolver has a winning level at strobe #1.
- grant_level  in  CAS_W  winning IR level.
- inta_strobe  in  1  one-cycle pulse per INTA falling edge, already synchronised.
- eoi  in  1  abort or complete the sequence; returns to IDLE.
- cas_in  in  CAS_W  sampled CAS pins.
- cas_out  out  CAS_W  CAS drive value.
- cas_oe  out  1  CAS output enable; the pad is Z when 0.
- vector_en  out  1  one-cycle pulse: this device drives the data byte for the current INTA.
- byte_sel  out  2  byte index for vector_en: 1 = first, 2 = second, 3 = third.
- slave_sel  out  1  slave mode: own ID matched in the current sequence.
- busy  out  1  state ≠ IDLE.
- timeout_err  out  1  one-cycle pulse on a timeout abort.

## Operation
- States: IDLE, P1 (after strobe #1), P2 (after strobe #2), P3 (after strobe #3, 8080 only).
- The last pulse is 2 when mode_8080 = 0 and 3 when mode_8080 = 1. The strobe after the last pulse is ignored.
- IDLE + strobe → P1. At this transition the block:
  - latches sp and mode_8080;
  - latches the level: grant_level if grant_valid = 1, else 7 (spurious), truncated to CAS_W bits;
  - clears the timeout counter.
- P1 + strobe → P2. P2 + strobe → P3 in 8080 mode.
- The cycle after the last pulse's strobe, the state returns to IDLE.
- Master, cascaded (icw3[level] = 1):
  - cas_out = level and cas_oe = 1 from P1 entry until IDLE.
  - vector_en is never asserted, except for the 8080 pulse-1 CALL byte (byte_sel = 1), which the master always supplies.
- Master, not cascaded: cas_oe = 0, and vector_en pulses for every data byte.
  - 8086 mode: pulse 2 only, byte_sel = 1 (the vector).
  - 8080 mode: pulses 1, 2 and 3, with byte_sel = 1, 2, 3.
- Slave:
  - cas_oe is always 0.
  - At strobe #2, slave_sel is set to (cas_in == icw3[CAS_W-1:0]) and held until IDLE.
  - If matched, vector_en pulses for pulse 2 (and pulse 3 in 8080 mode), with byte_sel = 1 in 8086 mode and 2, 3 in 8080 mode.
- eoi while busy: go to IDLE next cycle; cas_oe, slave_sel and busy go to 0. eoi in IDLE has no effect.
- Timeout:
  - The counter increments each non-IDLE cycle without a strobe and clears on every strobe.
  - When the count reaches TIMEOUT: go to IDLE and pulse timeout_err for one cycle.
- Priority of simultaneous events: reset > eoi > timeout > strobe.
- Changes to sp, mode_8080 or icw3 mid-sequence have no effect until the next IDLE → P1 transition.

## Timing
- Reset values: cas_out = 0, cas_oe = 0, vector_en = 0, byte_sel = 0, slave_sel = 0, busy = 0, timeout_err = 0, state = IDLE, counter = 0.
- All outputs are registered.
- A strobe in cycle t gives the state, cas_out/cas_oe, vector_en/byte_sel and slave_sel updates in cycle t+1.
- vector_en is high for exactly one cycle per qualifying strobe. byte_sel is valid only while vector_en = 1 and is 0 otherwise.
- After the last strobe at cycle t: the vector_en pulse occurs at t+1, IDLE is reached at t+2, and cas_oe and busy are 0 at t+2.
- Reset asserted mid-sequence: all outputs return to their reset values immediately (asynchronously). No timeout_err is generated.
- The timeout abort happens TIMEOUT cycles after the last strobe.

## Test plan
- Master, 8086 mode, icw3 = 0x08, grant level 3: two strobes → cas_out = 3 and cas_oe = 1 from t+1 after strobe #1 until 2 cycles after strobe #2; vector_en never asserted.
- Master, 8086 mode, icw3 = 0x00, grant level 5: strobe #2 → single vector_en pulse with byte_sel = 1; cas_oe stays 0.
- Slave, icw3 = 0x02:
  - cas_in = 2 at strobe #2 → slave_sel = 1, vector_en with byte_sel = 1.
  - Repeat with cas_in = 4 → slave_sel = 0, no vector_en.
- Master, 8080 mode, not cascaded, grant_valid = 0: three strobes → vector_en pulses with byte_sel = 1, 2, 3; level latched as 7.
- TIMEOUT = 4, master cascaded: one strobe then silence → timeout_err pulse exactly 4 cycles later, then busy = 0 and cas_oe = 0.
- Aborts:
  - eoi coincident with strobe #2 → IDLE, no vector_en.
  - reset asserted in P1 → all outputs 0 immediately.

Source files
------------

// File: rtl/cascade_sequencer.sv
// rtl/cascade_sequencer.sv - INTA acknowledge sequencer driving CAS lines and vector byte selects
module cascade_sequencer #(
    parameter int CAS_W   = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sp,
    input  logic                  mode_8080,
    input  logic [2**CAS_W-1:0]   icw3,
    input  logic                  grant_valid,
    input  logic [CAS_W-1:0]      grant_level,
    input  logic                  inta_strobe,
    input  logic                  eoi,
    input  logic [CAS_W-1:0]      cas_in,
    output logic [CAS_W-1:0]      cas_out,
    output logic                  cas_oe,
    output logic                  vector_en,
    output logic [1:0]            byte_sel,
    output logic                  slave_sel,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        P1   = 2'd1,
        P2   = 2'd2,
        P3   = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_sp;
    logic                   r_mode;
    logic [2**CAS_W-1:0]    r_icw3;
    logic [CAS_W-1:0]       r_level;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_latch;

    logic [CAS_W-1:0]       r_cas_out,   w_cas_out_nxt;
    logic                   r_cas_oe,    w_cas_oe_nxt;
    logic                   r_vector_en, w_vector_en_nxt;
    logic [1:0]             r_byte_sel,  w_byte_sel_nxt;
    logic                   r_slave_sel, w_slave_sel_nxt;
    logic                   r_busy;
    logic                   r_timeout_err, w_timeout_err_nxt;

    logic [CAS_W-1:0]       w_level_in;
    logic                   w_last;
    logic                   w_cascaded;
    logic                   w_match;

    // A missing grant acknowledges as the spurious level 7.
    assign w_level_in = grant_valid ? grant_level : CAS_W'(7);
    assign w_last     = (r_state == P3) || ((r_state == P2) && !r_mode);
    assign w_cascaded = r_icw3[r_level];
    assign w_match    = (cas_in == r_icw3[CAS_W-1:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_latch           = 1'b0;
        w_cas_out_nxt     = r_cas_out;
        w_cas_oe_nxt      = r_cas_oe;
        w_vector_en_nxt   = 1'b0;
        w_byte_sel_nxt    = 2'd0;
        w_slave_sel_nxt   = r_slave_sel;
        w_timeout_err_nxt = 1'b0;

        if (r_state == IDLE) begin
            if (inta_strobe) begin
                w_state_nxt     = P1;
                w_cnt_nxt       = '0;
                w_latch         = 1'b1;
                w_slave_sel_nxt = 1'b0;
                w_cas_oe_nxt    = sp && icw3[w_level_in];
                w_cas_out_nxt   = (sp && icw3[w_level_in]) ? w_level_in : '0;
                // The master always supplies the 8080 CALL opcode on pulse 1.
                if (sp && mode_8080) begin
                    w_vector_en_nxt = 1'b1;
                    w_byte_sel_nxt  = 2'd1;
                end
            end
        end else if (eoi || w_last) begin
            w_state_nxt     = IDLE;
            w_cas_oe_nxt    = 1'b0;
            w_cas_out_nxt   = '0;
            w_slave_sel_nxt = 1'b0;
        end else if (!inta_strobe) begin
            if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                w_state_nxt       = IDLE;
                w_cas_oe_nxt      = 1'b0;
                w_cas_out_nxt     = '0;
                w_slave_sel_nxt   = 1'b0;
                w_timeout_err_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end else begin
            w_cnt_nxt = '0;
            if (r_state == P1) begin
                w_state_nxt = P2;
                if (r_sp) begin
                    if (!w_cascaded) begin
                        w_vector_en_nxt = 1'b1;
                        w_byte_sel_nxt  = r_mode ? 2'd2 : 2'd1;
                    end
                end else begin
                    w_slave_sel_nxt = w_match;
                    if (w_match) begin
                        w_vector_en_nxt = 1'b1;
                        w_byte_sel_nxt  = r_mode ? 2'd2 : 2'd1;
                    end
                end
            end else begin
                w_state_nxt = P3;
                if ((r_sp && !w_cascaded) || (!r_sp && r_slave_sel)) begin
                    w_vector_en_nxt = 1'b1;
                    w_byte_sel_nxt  = 2'd3;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sp          <= 1'b0;
            r_mode        <= 1'b0;
            r_icw3        <= '0;
            r_level       <= '0;
            r_cnt         <= '0;
            r_cas_out     <= '0;
            r_cas_oe      <= 1'b0;
            r_vector_en   <= 1'b0;
            r_byte_sel    <= 2'd0;
            r_slave_sel   <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_latch) begin
                r_sp    <= sp;
                r_mode  <= mode_8080;
                r_icw3  <= icw3;
                r_level <= w_level_in;
            end
            r_cnt         <= w_cnt_nxt;
            r_cas_out     <= w_cas_out_nxt;
            r_cas_oe      <= w_cas_oe_nxt;
            r_vector_en   <= w_vector_en_nxt;
            r_byte_sel    <= w_byte_sel_nxt;
            r_slave_sel   <= w_slave_sel_nxt;
            r_busy        <= (w_state_nxt != IDLE);
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    assign cas_out     = r_cas_out;
    assign cas_oe      = r_cas_oe;
    assign vector_en   = r_vector_en;
    assign byte_sel    = r_byte_sel;
    assign slave_sel   = r_slave_sel;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_cascade_sequencer.sv
// tb/tb_cascade_sequencer.sv - directed and randomized bench against a pulse-level reference model
module tb_cascade_sequencer;

    localparam int CAS_W   = 3;
    localparam int TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       sp;
    logic       mode_8080;
    logic [7:0] icw3;
    logic       grant_valid;
    logic [2:0] grant_level;
    logic       inta_strobe;
    logic       eoi;
    logic [2:0] cas_in;
    logic [2:0] cas_out;
    logic       cas_oe;
    logic       vector_en;
    logic [1:0] byte_sel;
    logic       slave_sel;
    logic       busy;
    logic       timeout_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: which INTA pulse we are on (0 = none) and what was captured at pulse 1.
    int         m_pulse;
    int         m_silent;
    bit         m_master;
    bit         m_8080;
    logic [7:0] m_icw3;
    logic [2:0] m_level;
    logic [2:0] e_cas_out;
    bit         e_cas_oe, e_ven, e_slave, e_busy, e_terr;
    logic [1:0] e_bsel;

    always #5 clk = ~clk;

    cascade_sequencer #(.CAS_W(CAS_W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .sp          (sp),
        .mode_8080   (mode_8080),
        .icw3        (icw3),
        .grant_valid (grant_valid),
        .grant_level (grant_level),
        .inta_strobe (inta_strobe),
        .eoi         (eoi),
        .cas_in      (cas_in),
        .cas_out     (cas_out),
        .cas_oe      (cas_oe),
        .vector_en   (vector_en),
        .byte_sel    (byte_sel),
        .slave_sel   (slave_sel),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_pulse = 0; m_silent = 0;
        e_cas_out = 3'd0; e_cas_oe = 0; e_ven = 0; e_bsel = 2'd0;
        e_slave = 0; e_busy = 0; e_terr = 0;
    endtask

    task automatic end_sequence();
        m_pulse = 0; e_cas_oe = 0; e_cas_out = 3'd0; e_slave = 0;
    endtask

    // Called right after a rising edge with the inputs that edge sampled.
    task automatic model_step();
        int  last_pulse;
        bit  supplies;
        e_ven = 0; e_bsel = 2'd0; e_terr = 0;
        if (m_pulse == 0) begin
            if (inta_strobe) begin
                m_pulse  = 1;
                m_silent = 0;
                m_master = sp;
                m_8080   = mode_8080;
                m_icw3   = icw3;
                m_level  = grant_valid ? grant_level : 3'd7;
                e_slave  = 0;
                e_cas_oe = m_master && m_icw3[m_level];
                e_cas_out = e_cas_oe ? m_level : 3'd0;
                if (m_master && m_8080) begin
                    e_ven = 1; e_bsel = 2'd1;
                end
            end
        end else begin
            last_pulse = m_8080 ? 3 : 2;
            if (eoi || m_pulse == last_pulse) begin
                end_sequence();
            end else if (!inta_strobe) begin
                m_silent++;
                if (m_silent == TIMEOUT) begin
                    end_sequence();
                    e_terr = 1;
                end
            end else begin
                m_silent = 0;
                m_pulse++;
                if (m_pulse == 2 && !m_master) e_slave = (cas_in == m_icw3[2:0]);
                supplies = m_master ? !m_icw3[m_level] : e_slave;
                if (supplies) begin
                    e_ven  = 1;
                    e_bsel = m_8080 ? 2'(m_pulse) : 2'(m_pulse - 1);
                end
            end
        end
        e_busy = (m_pulse != 0);
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".cas_out"},     32'(cas_out),     32'(e_cas_out));
        check({tag, ".cas_oe"},      32'(cas_oe),      32'(e_cas_oe));
        check({tag, ".vector_en"},   32'(vector_en),   32'(e_ven));
        check({tag, ".byte_sel"},    32'(byte_sel),    32'(e_bsel));
        check({tag, ".slave_sel"},   32'(slave_sel),   32'(e_slave));
        check({tag, ".busy"},        32'(busy),        32'(e_busy));
        check({tag, ".timeout_err"}, 32'(timeout_err), 32'(e_terr));
    endtask

    // Entered and left at a falling edge.
    task automatic tick(input string tag, input bit strb, input bit e);
        inta_strobe = strb;
        eoi         = e;
        @(posedge clk);
        model_step();
        @(negedge clk);
        inta_strobe = 0;
        eoi         = 0;
        compare_all(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1;
        #1;
        model_reset();
        compare_all(tag);
        @(negedge clk);
        reset = 0;
    endtask

    task automatic setup(input bit s, input bit m, input logic [7:0] i3, input bit gv, input logic [2:0] gl, input logic [2:0] ci);
        sp = s; mode_8080 = m; icw3 = i3; grant_valid = gv; grant_level = gl; cas_in = ci;
    endtask

    initial begin
        int tmo_seen;
        reset = 1; inta_strobe = 0; eoi = 0;
        setup(1, 0, 8'h00, 0, 3'd0, 3'd0);
        @(negedge clk);
        do_reset("reset");

        setup(1, 0, 8'h08, 1, 3'd3, 3'd0);
        tick("m86_casc", 1, 0); tick("m86_casc", 0, 0); tick("m86_casc", 1, 0);
        tick("m86_casc", 0, 0); tick("m86_casc", 0, 0);

        setup(1, 0, 8'h00, 1, 3'd5, 3'd0);
        tick("m86_flat", 1, 0); tick("m86_flat", 1, 0);
        tick("m86_flat", 0, 0); tick("m86_flat", 0, 0);

        setup(0, 0, 8'h02, 1, 3'd0, 3'd2);
        tick("slv_hit", 1, 0); tick("slv_hit", 1, 0);
        tick("slv_hit", 0, 0); tick("slv_hit", 0, 0);
        setup(0, 0, 8'h02, 1, 3'd0, 3'd4);
        tick("slv_miss", 1, 0); tick("slv_miss", 1, 0);
        tick("slv_miss", 0, 0); tick("slv_miss", 0, 0);

        setup(0, 1, 8'h05, 1, 3'd0, 3'd5);
        tick("slv80", 1, 0); tick("slv80", 1, 0); tick("slv80", 1, 0);
        tick("slv80", 0, 0); tick("slv80", 0, 0);

        setup(1, 1, 8'h00, 0, 3'd2, 3'd0);
        tick("m80_spur", 1, 0); tick("m80_spur", 1, 0); tick("m80_spur", 1, 0);
        tick("m80_spur", 1, 0); tick("m80_spur", 0, 0);
        setup(1, 1, 8'h80, 0, 3'd2, 3'd0);
        tick("m80_lvl7", 1, 0);
        check("m80_lvl7.level", 32'(cas_out), 32'd7);
        tick("m80_lvl7", 1, 0); tick("m80_lvl7", 1, 0); tick("m80_lvl7", 0, 0);

        setup(1, 0, 8'hff, 1, 3'd6, 3'd0);
        tick("tmo", 1, 0);
        tmo_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick("tmo", 0, 0);
            if (timeout_err) tmo_seen++;
        end
        check("tmo.pulses", 32'(tmo_seen), 32'd1);

        setup(1, 0, 8'h00, 1, 3'd1, 3'd0);
        tick("eoi_s2", 1, 0); tick("eoi_s2", 1, 1); tick("eoi_s2", 0, 0);

        setup(1, 0, 8'h02, 1, 3'd1, 3'd0);
        tick("rst_p1", 1, 0);
        do_reset("rst_p1");
        tick("rst_p1", 0, 0);

        for (int c = 0; c < 3000; c++) begin
            sp          = 1'($urandom);
            mode_8080   = 1'($urandom);
            icw3        = 8'($urandom);
            grant_valid = ($urandom_range(0, 3) != 0);
            grant_level = 3'($urandom);
            cas_in      = ($urandom_range(0, 1) == 1) ? icw3[2:0] : 3'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                do_reset("rnd_rst");
            end else begin
                tick("rnd", ($urandom_range(0, 9) < 4), ($urandom_range(0, 39) == 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
